// File: rtl/time_disp_scan.sv
// time_disp_scan: scans a 6-digit common-anode 7-segment display showing HH MM SS.
// The hour/minu/seco inputs are sampled once per frame into a shadow register, so a frame never tears.
// The optional macro DP_BLINK_EN lights the decimal points on the hour-ones and minute-ones digits
// whenever the sampled seconds value is even.
module time_disp_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] hour,
    input  logic [5:0] minu,
    input  logic [5:0] seco,
    output logic [5:0] sel,
    output logic [7:0] seg
);

    localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [5:0]    h_q, h_d, m_q, m_d, s_q, s_d;
    logic [5:0]    sel_q, sel_d;
    logic [7:0]    seg_q, seg_d;
    logic          tick, frame_end;
    logic [5:0]    val;
    logic [2:0]    tens;
    logic [5:0]    tens_x10;
    logic [3:0]    ones, digit;
    logic          dp;

    // Binary-to-tens for the full 6-bit range; 60..63 give 6 so out-of-range values are not clamped.
    function automatic logic [2:0] div10(input logic [5:0] v);
        return (v >= 6'd60) ? 3'd6 :
               (v >= 6'd50) ? 3'd5 :
               (v >= 6'd40) ? 3'd4 :
               (v >= 6'd30) ? 3'd3 :
               (v >= 6'd20) ? 3'd2 :
               (v >= 6'd10) ? 3'd1 : 3'd0;
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a} for a decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign tick      = (cnt_q == CNT_LAST);
    assign frame_end = tick && (idx_q == 3'd5);

    // Divider, digit index, shadow sample and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
            h_q   <= 6'd0;
            m_q   <= 6'd0;
            s_q   <= 6'd0;
            sel_q <= 6'b111111;
            seg_q <= 8'hFF;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            h_q   <= h_d;
            m_q   <= m_d;
            s_q   <= s_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    // Next-state: divider wrap advances the digit; the 5->0 wrap resamples the time inputs.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = !tick ? idx_q : (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        h_d   = frame_end ? hour : h_q;
        m_d   = frame_end ? minu : m_q;
        s_d   = frame_end ? seco : s_q;
    end

    // Output decode for the current digit: field select, BCD split, segment pattern and select line.
    always_comb begin
        val      = (idx_q < 3'd2) ? h_q : (idx_q < 3'd4) ? m_q : s_q;
        tens     = div10(val);
        tens_x10 = {3'b000, tens} * 6'd10;
        ones     = 4'(val - tens_x10);
        digit    = idx_q[0] ? ones : {1'b0, tens};
`ifdef DP_BLINK_EN
        dp       = !(((idx_q == 3'd1) || (idx_q == 3'd3)) && !s_q[0]);
`else
        dp       = 1'b1;
`endif
        seg_d    = {dp, seg7(digit)};
        sel_d    = ~(6'b100000 >> idx_q);
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule
